top_module_hls_deadlock_report_ctrl: RTL and testbench

Central sequencer for the per-process deadlock detection units of the HLS dataflow region.
- Collects the per-process deadlock flags and picks one flagged process round-robin.
- Launches a report token from that process, traces the token around the dependence cycle, then clears it.
- Freezes the units during tracing and presents a sticky deadlock report (origin process id plus cycle membership mask) until the host acknowledges.

---
 rtl/top_module_hls_deadlock_report_ctrl.sv | 121 ++++++++++++
 tb/tb_top_module_hls_deadlock_report_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_module_hls_deadlock_report_ctrl.sv
// Deadlock report sequencer for the HLS dataflow region.
// Picks a flagged process round-robin, traces its token, holds the report.
module top_module_hls_deadlock_report_ctrl #(
    parameter int PROC_NUM = 4,
    parameter int ID_W     = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic [PROC_NUM-1:0] token_return_vec,
    input  logic                ack,
    output logic                dl_detect_bcast,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic [PROC_NUM-1:0] token_clear_vec,
    output logic                deadlock_valid,
    output logic [ID_W-1:0]     deadlock_proc_id,
    output logic [PROC_NUM-1:0] deadlock_chain,
    output logic [7:0]          abort_cnt
);

    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_TRACE,
        S_REPORT
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     sel;
    logic [TW-1:0]       timer;
    logic [PROC_NUM-1:0] chain;

    logic [PROC_NUM-1:0] sel_oh;
    logic                ret_hit;
    logic                tmo;
    logic [ID_W-1:0]     sel_next;
    logic [ID_W-1:0]     pick;
    logic [ID_W-1:0]     pick_hi;
    logic [ID_W-1:0]     pick_lo;
    logic                hit_hi;

    assign sel_oh   = PROC_NUM'(1) << sel;
    assign ret_hit  = |(token_return_vec & sel_oh);
    assign tmo      = (timer == TW'(TIMEOUT - 1));
    assign sel_next = (sel == ID_W'(PROC_NUM - 1)) ? '0 : sel + 1'b1;

    // Descending scan: the last hit written is the lowest index.
    always_comb begin
        pick_hi = '0;
        pick_lo = '0;
        hit_hi  = 1'b0;
        for (int p = PROC_NUM - 1; p >= 0; p--) begin
            if (dl_detect_vec[p]) begin
                if (ID_W'(p) >= rr_ptr) begin
                    pick_hi = ID_W'(p);
                    hit_hi  = 1'b1;
                end
                pick_lo = ID_W'(p);
            end
        end
        pick = hit_hi ? pick_hi : pick_lo;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            sel       <= '0;
            timer     <= '0;
            chain     <= '0;
            abort_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (|dl_detect_vec) begin
                        sel   <= pick;
                        state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    chain <= sel_oh;
                    timer <= '0;
                    state <= S_TRACE;
                end
                S_TRACE: begin
                    chain <= chain | token_return_vec;
                    timer <= timer + 1'b1;
                    if (ret_hit) begin
                        state <= S_REPORT;
                    end else if (tmo) begin
                        state  <= S_IDLE;
                        rr_ptr <= sel_next;
                        chain  <= '0;
                        if (abort_cnt != 8'hFF) begin
                            abort_cnt <= abort_cnt + 8'd1;
                        end
                    end
                end
                S_REPORT: begin
                    if (ack) begin
                        state  <= S_IDLE;
                        rr_ptr <= sel_next;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign dl_detect_bcast  = (state != S_IDLE);
    assign origin_vec       = (state == S_LAUNCH) ? sel_oh : '0;
    assign token_clear_vec  = (state == S_TRACE && ret_hit) ? sel_oh : '0;
    assign deadlock_valid   = (state == S_REPORT);
    assign deadlock_proc_id = deadlock_valid ? sel : '0;
    assign deadlock_chain   = deadlock_valid ? chain : '0;

endmodule

// File: tb/tb_top_module_hls_deadlock_report_ctrl.sv
// Bench for the deadlock report sequencer.
// Directed scenarios plus random traffic against a behavioural model.
module tb_top_module_hls_deadlock_report_ctrl;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] dl_detect_vec = '0;
    logic [N-1:0] token_return_vec = '0;
    logic         ack = 1'b0;
    logic         dl_detect_bcast;
    logic [N-1:0] origin_vec;
    logic [N-1:0] token_clear_vec;
    logic         deadlock_valid;
    logic [IW-1:0] deadlock_proc_id;
    logic [N-1:0] deadlock_chain;
    logic [7:0]   abort_cnt;

    top_module_hls_deadlock_report_ctrl #(
        .PROC_NUM(N),
        .ID_W(IW),
        .TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .dl_detect_vec(dl_detect_vec),
        .token_return_vec(token_return_vec),
        .ack(ack),
        .dl_detect_bcast(dl_detect_bcast),
        .origin_vec(origin_vec),
        .token_clear_vec(token_clear_vec),
        .deadlock_valid(deadlock_valid),
        .deadlock_proc_id(deadlock_proc_id),
        .deadlock_chain(deadlock_chain),
        .abort_cnt(abort_cnt)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // model: phase 0 idle, 1 launch, 2 trace, 3 report
    int m_ph, m_rr, m_sel, m_age, m_chain, m_abort;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ph = 0;
        m_rr = 0;
        m_sel = 0;
        m_age = 0;
        m_chain = 0;
        m_abort = 0;
    endtask

    task automatic m_step();
        int dl;
        int tr;
        bit found;
        dl = int'(dl_detect_vec);
        tr = int'(token_return_vec);
        found = 0;
        case (m_ph)
            0: begin
                for (int k = 0; k < N; k++) begin
                    int p;
                    p = (m_rr + k) % N;
                    if (!found && ((dl >> p) & 1) != 0) begin
                        m_sel = p;
                        found = 1;
                    end
                end
                if (found) m_ph = 1;
            end
            1: begin
                m_chain = 1 << m_sel;
                m_age = 0;
                m_ph = 2;
            end
            2: begin
                m_chain = m_chain | tr;
                if (((tr >> m_sel) & 1) != 0) begin
                    m_ph = 3;
                end else if (m_age == TO - 1) begin
                    m_ph = 0;
                    m_abort = (m_abort < 255) ? m_abort + 1 : 255;
                    m_rr = (m_sel + 1) % N;
                    m_chain = 0;
                end
                m_age++;
            end
            default: begin
                if (ack) begin
                    m_ph = 0;
                    m_rr = (m_sel + 1) % N;
                end
            end
        endcase
    endtask

    task automatic m_cmp();
        int tr;
        int oh;
        bit rep;
        tr = int'(token_return_vec);
        oh = 1 << m_sel;
        rep = (m_ph == 3);
        chk("bcast", 32'(dl_detect_bcast), (m_ph != 0) ? 1 : 0);
        chk("origin", 32'(origin_vec), (m_ph == 1) ? oh : 0);
        chk("clear", 32'(token_clear_vec),
            (m_ph == 2 && ((tr >> m_sel) & 1) != 0) ? oh : 0);
        chk("valid", 32'(deadlock_valid), rep ? 1 : 0);
        chk("proc_id", 32'(deadlock_proc_id), rep ? m_sel : 0);
        chk("chain", 32'(deadlock_chain), rep ? m_chain : 0);
        chk("abort_cnt", 32'(abort_cnt), m_abort);
    endtask

    initial begin
        m_reset();
        forever begin
            @(negedge clock);
            if (!reset) m_reset();
            m_cmp();
            @(posedge clock);
            if (reset) m_step();
            else m_reset();
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_origin(input logic [N-1:0] exp, input string nm);
        int n;
        n = 0;
        @(negedge clock);
        while (origin_vec == '0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk(nm, 32'(origin_vec), 32'(exp));
    endtask

    // from the LAUNCH negedge: return on first TRACE cycle, then ack
    task automatic finish_trace(input logic [N-1:0] oh);
        cyc();
        dl_detect_vec = '0;
        token_return_vec = oh;
        cyc();
        token_return_vec = '0;
        ack = 1'b1;
        cyc();
        ack = 1'b0;
    endtask

    initial begin
        logic [N-1:0] t;
        dl_detect_vec = 4'b1111;
        repeat (3) cyc();
        @(negedge clock);
        chk("rst_origin", 32'(origin_vec), 0);
        chk("rst_bcast", 32'(dl_detect_bcast), 0);
        chk("rst_valid", 32'(deadlock_valid), 0);
        chk("rst_abort", 32'(abort_cnt), 0);
        cyc();
        reset = 1'b1;
        wait_origin(4'b0001, "first_origin");
        finish_trace(4'b0001);

        dl_detect_vec = 4'b0100;
        cyc();
        dl_detect_vec = '0;
        @(negedge clock);
        chk("single_origin", 32'(origin_vec), 'h4);
        cyc();
        @(negedge clock);
        chk("single_origin_off", 32'(origin_vec), 0);
        cyc();
        token_return_vec = 4'b1000;
        ack = 1'b1;
        cyc();
        token_return_vec = '0;
        ack = 1'b0;
        @(negedge clock);
        chk("clear_early", 32'(token_clear_vec), 0);
        cyc();
        token_return_vec = 4'b0100;
        @(negedge clock);
        chk("clear_pulse", 32'(token_clear_vec), 'h4);
        cyc();
        token_return_vec = '0;
        @(negedge clock);
        chk("rep_valid", 32'(deadlock_valid), 1);
        chk("rep_id", 32'(deadlock_proc_id), 2);
        chk("rep_chain", 32'(deadlock_chain), 'hC);
        chk("clear_after", 32'(token_clear_vec), 0);
        cyc();
        @(negedge clock);
        chk("rep_hold", 32'(deadlock_chain), 'hC);
        cyc();
        ack = 1'b1;
        cyc();
        ack = 1'b0;

        dl_detect_vec = 4'b0101;
        wait_origin(4'b0001, "rr_wrap");
        finish_trace(4'b0001);
        dl_detect_vec = 4'b0101;
        wait_origin(4'b0100, "rr_next");
        finish_trace(4'b0100);

        dl_detect_vec = 4'b0010;
        wait_origin(4'b0010, "to_origin");
        cyc();
        dl_detect_vec = '0;
        repeat (7) cyc();
        @(negedge clock);
        chk("to_last_trace", 32'(dl_detect_bcast), 1);
        cyc();
        dl_detect_vec = 4'b1011;
        @(negedge clock);
        chk("to_idle", 32'(dl_detect_bcast), 0);
        chk("to_abort", 32'(abort_cnt), 1);
        chk("to_novalid", 32'(deadlock_valid), 0);
        wait_origin(4'b1000, "to_rr_next");

        cyc();
        dl_detect_vec = '0;
        repeat (7) cyc();
        token_return_vec = 4'b1000;
        @(negedge clock);
        chk("sim_clear", 32'(token_clear_vec), 'h8);
        cyc();
        token_return_vec = '0;
        @(negedge clock);
        chk("sim_valid", 32'(deadlock_valid), 1);
        chk("sim_abort", 32'(abort_cnt), 1);

        cyc();
        ack = 1'b1;
        dl_detect_vec = 4'b0100;
        @(negedge clock);
        chk("ack_first", 32'(deadlock_valid), 1);
        cyc();
        @(negedge clock);
        chk("ack_drop", 32'(deadlock_valid), 0);
        cyc();
        cyc();
        ack = 1'b0;
        dl_detect_vec = '0;

        for (int i = 0; i < 3000; i++) begin
            cyc();
            dl_detect_vec = $urandom_range(0, 1) ? 4'($urandom) : 4'b0;
            for (int b = 0; b < N; b++) t[b] = ($urandom_range(0, 5) == 0);
            token_return_vec = t;
            ack = ($urandom_range(0, 2) == 0);
            reset = (i % 500 == 250) ? 1'b0 : 1'b1;
        end

        cyc();
        reset = 1'b0;
        dl_detect_vec = '0;
        token_return_vec = '0;
        ack = 1'b0;
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 2700; i++) begin
            cyc();
            dl_detect_vec = 4'($urandom_range(1, 15));
        end
        @(negedge clock);
        chk("abort_sat", 32'(abort_cnt), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
